// File: rtl/ysyx_24120013_exu_pkg.sv
// Shared definitions for the multi-cycle execute unit: op codes, FSM states,
// and counter sizing.
package ysyx_24120013_exu_pkg;

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_AND   = 2;
    localparam int OP_OR    = 3;
    localparam int OP_XOR   = 4;
    localparam int OP_SLL   = 5;
    localparam int OP_SRL   = 6;
    localparam int OP_SRA   = 7;
    localparam int OP_SLT   = 8;
    localparam int OP_SLTU  = 9;
    localparam int OP_MUL   = 10;
    localparam int OP_MULHU = 11;
    localparam int OP_DIVU  = 12;
    localparam int OP_REMU  = 13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } exu_state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_WIDTH = cnt_width(32);

endpackage

// File: rtl/ysyx_24120013_exu_mdu.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
// The accumulator holds {hi, lo}: {product_hi, product_lo} or {remainder, quotient}.
module ysyx_24120013_exu_mdu
    import ysyx_24120013_exu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  kill,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] res_lo,
    output logic [DATA_WIDTH-1:0] res_hi
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = cnt_width(DATA_WIDTH);

    logic [CW-1:0]  cnt;
    logic           div_q;
    logic [W-1:0]   opnd;
    logic [2*W-1:0] acc, acc_n;
    logic [W:0]     sum, rsh, diff;

    always_comb begin
        sum   = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
        rsh   = acc[2*W-1:W-1];
        diff  = rsh - {1'b0, opnd};
        acc_n = acc;
        if (div_q) begin
            if (rsh >= {1'b0, opnd}) acc_n = {diff[W-1:0], acc[W-2:0], 1'b1};
            else                     acc_n = {rsh[W-1:0],  acc[W-2:0], 1'b0};
        end else begin
            if (acc[0]) acc_n = {sum, acc[W-1:1]};
            else        acc_n = {1'b0, acc[2*W-1:1]};
        end
    end

    // Result is exposed combinationally so the top can register it on the final step.
    assign done   = busy && (cnt == '0);
    assign res_lo = acc_n[W-1:0];
    assign res_hi = acc_n[2*W-1:W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            div_q <= 1'b0;
            opnd  <= '0;
            acc   <= '0;
        end else if (kill) begin
            busy <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CW'(DATA_WIDTH - 1);
            div_q <= is_div;
            opnd  <= is_div ? b : a;
            acc   <= {{W{1'b0}}, (is_div ? a : b)};
        end else if (busy) begin
            acc <= acc_n;
            cnt <= cnt - CW'(1);
            if (cnt == '0) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_24120013_exu_mc.sv
// Multi-cycle execute unit: single-cycle ALU plus iterative mul/div, with a
// registered writeback triple under valid/ready.
module ysyx_24120013_exu_mc
    import ysyx_24120013_exu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OP_WIDTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_WIDTH-1:0]       op,
    input  logic [DATA_WIDTH-1:0]     rs1_data,
    input  logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic [DATA_WIDTH-1:0]     imm,
    input  logic                      use_imm,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      EXU_wen,
    output logic [REG_ADDR_WIDTH-1:0] EXU_waddr,
    output logic [DATA_WIDTH-1:0]     EXU_wdata
);
    localparam int CW = cnt_width(DATA_WIDTH);

    exu_state_t state, state_n;

    logic [DATA_WIDTH-1:0]     opb, alu_res, mdu_lo, mdu_hi;
    logic [OP_WIDTH-1:0]       op_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic wen_q, accept, iter, is_mdu, is_div, valid_op, sel_hi;
    logic mdu_busy, mdu_done;

    assign opb      = use_imm ? imm : rs2_data;
    assign is_mdu   = (int'(op) >= OP_MUL) && (int'(op) <= OP_REMU);
    assign is_div   = (int'(op) == OP_DIVU) || (int'(op) == OP_REMU);
    assign valid_op = int'(op) <= OP_REMU;
    // Multiply or divide by zero has a closed-form answer, so it skips the iteration.
    assign iter     = is_mdu && (opb != '0);
    assign accept   = in_valid && in_ready;
    assign sel_hi   = (int'(op_q) == OP_MULHU) || (int'(op_q) == OP_REMU);
    assign out_valid = (state == S_DONE);

    always_comb begin
        alu_res = '0;
        case (int'(op))
            OP_ADD:  alu_res = rs1_data + opb;
            OP_SUB:  alu_res = rs1_data - opb;
            OP_AND:  alu_res = rs1_data & opb;
            OP_OR:   alu_res = rs1_data | opb;
            OP_XOR:  alu_res = rs1_data ^ opb;
            OP_SLL:  alu_res = rs1_data << opb[CW-1:0];
            OP_SRL:  alu_res = rs1_data >> opb[CW-1:0];
            OP_SRA:  alu_res = $signed(rs1_data) >>> opb[CW-1:0];
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1_data) < $signed(opb)};
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, rs1_data < opb};
            OP_DIVU: alu_res = '1;
            OP_REMU: alu_res = rs1_data;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        state_n  = state;
        case (state)
            S_IDLE: in_ready = !mdu_busy;
            S_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        if (flush) in_ready = 1'b0;

        if (flush) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) state_n = iter ? S_BUSY : S_DONE;
                S_BUSY: if (mdu_done) state_n = S_DONE;
                S_DONE: if (out_ready) state_n = accept ? (iter ? S_BUSY : S_DONE) : S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            EXU_wen   <= 1'b0;
            EXU_waddr <= '0;
            EXU_wdata <= '0;
        end else if (flush) begin
            EXU_wen <= 1'b0;
        end else begin
            if (state == S_DONE && out_ready) EXU_wen <= 1'b0;
            if (mdu_done) begin
                EXU_wdata <= sel_hi ? mdu_hi : mdu_lo;
                EXU_waddr <= rd_q;
                EXU_wen   <= wen_q;
            end
            if (accept) begin
                op_q  <= op;
                rd_q  <= rd;
                wen_q <= (rd != '0);
                if (!iter) begin
                    EXU_wdata <= alu_res;
                    EXU_waddr <= rd;
                    EXU_wen   <= (rd != '0) && valid_op;
                end
            end
        end
    end

    ysyx_24120013_exu_mdu #(.DATA_WIDTH(DATA_WIDTH)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && iter),
        .kill   (flush),
        .is_div (is_div),
        .a      (rs1_data),
        .b      (opb),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .res_lo (mdu_lo),
        .res_hi (mdu_hi)
    );

endmodule

// File: tb/tb_ysyx_24120013_exu_mc.sv
// Directed scoreboard bench for the multi-cycle execute unit.
module tb_ysyx_24120013_exu_mc;
    import ysyx_24120013_exu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 4;

    logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, use_imm = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, EXU_wen;
    logic [OW-1:0] op = '0;
    logic [DW-1:0] rs1_data = '0, rs2_data = '0, imm = '0, EXU_wdata;
    logic [AW-1:0] rd = '0, EXU_waddr;

    always #5 clk = ~clk;

    ysyx_24120013_exu_mc #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .OP_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .use_imm(use_imm),
        .rd(rd), .out_valid(out_valid), .out_ready(out_ready), .EXU_wen(EXU_wen),
        .EXU_waddr(EXU_waddr), .EXU_wdata(EXU_wdata)
    );

    typedef logic [37:0] wb_t;
    wb_t sb[$];
    int passed = 0, total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sb.push_back({w, a, d});
    endtask

    task automatic set_op(input int o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] im, input logic ui, input logic [AW-1:0] r);
        op = OW'(o); rs1_data = a; rs2_data = b; imm = im; use_imm = ui; rd = r;
        in_valid = 1'b1;
    endtask

    task automatic issue(input int o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] im, input logic ui, input logic [AW-1:0] r);
        set_op(o, a, b, im, ui, r);
        #1 check("issue_rdy", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        wb_t e;
        e = '1;
        if (sb.size() != 0) e = sb.pop_front();
        check({tag, "_vld"}, 64'(out_valid), 64'(1));
        check(tag, 64'({EXU_wen, EXU_waddr, EXU_wdata}), 64'(e));
    endtask

    // Called at the first sample after the accepting edge (n=1).
    task automatic wait_result(input string tag, input int lat, input int busy_exp);
        int n, b;
        n = 1; b = 0;
        while (!out_valid && n < 100) begin
            if (!in_ready) b++;
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_busy"}, 64'(b), 64'(busy_exp));
        pop_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        repeat (2) tick();
        check("rst_out", 64'({out_valid, EXU_wen, EXU_waddr, EXU_wdata}), 64'(0));
        rst = 1'b1;
        #1 check("rst_rdy", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        tick();

        // back-to-back ALU stream, one result per cycle
        set_op(OP_ADD, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 5'd3); push(1'b1, 5'd3, 32'h0000_0004);
        tick(); pop_check("add");
        set_op(OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd7); push(1'b1, 5'd7, 32'hF800_0000);
        tick(); pop_check("sra");
        set_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd0); push(1'b0, 5'd0, 32'h0000_0001);
        tick(); pop_check("slt");
        in_valid = 1'b0;
        tick();
        check("drain", 64'(out_valid), 64'(0));

        issue(OP_SUB, 32'd0, 32'd1, 32'd0, 1'b0, 5'd9); push(1'b1, 5'd9, 32'hFFFF_FFFF);
        wait_result("sub_wrap", 1, 0); tick();
        issue(14, 32'd5, 32'd5, 32'd0, 1'b0, 5'd9); push(1'b0, 5'd9, 32'd0);
        wait_result("op14", 1, 0); tick();

        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd10); push(1'b1, 5'd10, 32'hFFFF_FFFE);
        wait_result("mulhu", 33, 32); tick();
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd11); push(1'b1, 5'd11, 32'h0000_0001);
        wait_result("mul", 33, 32); tick();
        issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 5'd12); push(1'b1, 5'd12, 32'd14);
        wait_result("divu", 33, 32); tick();
        issue(OP_REMU, 32'd100, 32'd0, 32'd7, 1'b1, 5'd13); push(1'b1, 5'd13, 32'd2);
        wait_result("remu", 33, 32); tick();
        issue(OP_DIVU, 32'h0000_DEAD, 32'd0, 32'd0, 1'b0, 5'd5); push(1'b1, 5'd5, 32'hFFFF_FFFF);
        wait_result("divu0", 1, 0); tick();
        issue(OP_REMU, 32'h0000_1234, 32'd0, 32'd0, 1'b0, 5'd6); push(1'b1, 5'd6, 32'h0000_1234);
        wait_result("remu0", 1, 0); tick();

        // backpressure: hold in DONE, then accept in the same cycle as retire
        out_ready = 1'b0;
        issue(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 1'b0, 5'd4); push(1'b1, 5'd4, 32'h0000_FF00);
        set_op(OP_ADD, 32'd7, 32'd8, 32'd0, 1'b0, 5'd8);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold", 64'({out_valid, EXU_wen, EXU_waddr, EXU_wdata}), 64'({1'b1, sb[0]}));
            check("bp_rdy0", 64'(in_ready), 64'(0));
            tick();
        end
        out_ready = 1'b1;
        #1 check("bp_rdy1", 64'(in_ready), 64'(1));
        pop_check("bp_xor");
        push(1'b1, 5'd8, 32'd15);
        tick(); in_valid = 1'b0;
        pop_check("bp_add");
        tick();

        // flush on BUSY cycle 10 of a divide
        issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 5'd2);
        repeat (9) tick();
        flush = 1'b1;
        #1 check("fl_rdy", 64'(in_ready), 64'(0));
        tick(); flush = 1'b0;
        seen = 0;
        repeat (40) begin if (out_valid) seen++; tick(); end
        check("fl_noval", 64'(seen), 64'(0));
        check("fl_wen", 64'(EXU_wen), 64'(0));
        check("fl_idle", 64'(in_ready), 64'(1));
        issue(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd1); push(1'b1, 5'd1, 32'd2);
        wait_result("fl_add", 1, 0); tick();

        // reset in the middle of BUSY
        issue(OP_MUL, 32'd3, 32'd5, 32'd0, 1'b0, 5'd2);
        repeat (5) tick();
        rst = 1'b0;
        #1 check("rmb_val", 64'(out_valid), 64'(0));
        tick(); rst = 1'b1;
        seen = 0;
        repeat (40) begin if (out_valid) seen++; tick(); end
        check("rmb_noval", 64'(seen), 64'(0));

        // async reset while holding a nonzero result
        out_ready = 1'b0;
        issue(OP_OR, 32'h0000_00A5, 32'h0000_5A00, 32'd0, 1'b0, 5'd15); push(1'b1, 5'd15, 32'h0000_5AA5);
        pop_check("or_hold");
        rst = 1'b0;
        #1 check("rst_mid", 64'({out_valid, EXU_wen, EXU_waddr, EXU_wdata}), 64'(0));
        tick(); rst = 1'b1;
        #1 check("rst_rdy2", 64'(in_ready), 64'(1));

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
